// File: rtl/axil_mem_slave.sv
// AXI4-Lite memory slave: byte-strobed RAM, console byte port and sticky pass flag.
// Read and write channels run independent FSMs with programmable wait states.

module axil_mem_slave #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEM_BYTES    = 131072,
    parameter int                    RD_WAIT      = 0,
    parameter int                    WR_WAIT      = 0,
    parameter logic [ADDR_WIDTH-1:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [ADDR_WIDTH-1:0] PASS_ADDR    = 32'h2000_0000,
    parameter logic [31:0]           PASS_VALUE   = 32'd123456789
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    mem_axi_awvalid,
    output logic                    mem_axi_awready,
    input  logic [ADDR_WIDTH-1:0]   mem_axi_awaddr,
    input  logic [2:0]              mem_axi_awprot,
    input  logic                    mem_axi_wvalid,
    output logic                    mem_axi_wready,
    input  logic [DATA_WIDTH-1:0]   mem_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_axi_wstrb,
    output logic                    mem_axi_bvalid,
    input  logic                    mem_axi_bready,
    output logic [1:0]              mem_axi_bresp,
    input  logic                    mem_axi_arvalid,
    output logic                    mem_axi_arready,
    input  logic [ADDR_WIDTH-1:0]   mem_axi_araddr,
    input  logic [2:0]              mem_axi_arprot,
    output logic                    mem_axi_rvalid,
    input  logic                    mem_axi_rready,
    output logic [DATA_WIDTH-1:0]   mem_axi_rdata,
    output logic [1:0]              mem_axi_rresp,
    output logic                    console_valid,
    output logic [7:0]              console_data,
    output logic                    tests_passed
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(MEM_BYTES) - ADDR_LSB;
    localparam int DEPTH    = MEM_BYTES / STRB_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;
    typedef enum logic [1:0] {SEL_RAM, SEL_CONSOLE, SEL_PASS, SEL_ERR} sel_t;

    function automatic sel_t decode(input logic [ADDR_WIDTH-1:0] addr);
        if (addr < ADDR_WIDTH'(MEM_BYTES)) return SEL_RAM;
        if (addr == CONSOLE_ADDR)          return SEL_CONSOLE;
        if (addr == PASS_ADDR)             return SEL_PASS;
        return SEL_ERR;
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Ready outputs stay low until the first clock after reset release.
    logic r_live;
    always_ff @(posedge clk) begin
        if (!resetn) r_live <= 1'b0;
        else         r_live <= 1'b1;
    end

    logic w_unused;
    assign w_unused = &{1'b0, mem_axi_awprot, mem_axi_arprot};

    // ---------------- read channel ----------------
    rd_state_t             r_rd_state, w_rd_next;
    logic [3:0]            r_rd_cnt;
    logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr;
    logic                  r_rvalid, w_arready, w_ar_fire, w_rd_enter;
    logic [DATA_WIDTH-1:0] r_rdata, w_rd_data;
    logic [1:0]            r_rresp, w_rd_resp;
    sel_t                  w_rd_sel;

    always_ff @(posedge clk) begin
        if (!resetn) r_rd_state <= R_IDLE;
        else         r_rd_state <= w_rd_next;
    end

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_ar_fire) w_rd_next = (RD_WAIT == 0) ? R_RESP : R_WAIT;
            R_WAIT:  if (r_rd_cnt <= 4'd1) w_rd_next = R_RESP;
            R_RESP:  if (mem_axi_rready) w_rd_next = R_IDLE;
            default: w_rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_arready = r_live && (r_rd_state == R_IDLE);
    end

    assign w_ar_fire  = mem_axi_arvalid && w_arready;
    assign w_rd_enter = (w_rd_next == R_RESP) && (r_rd_state != R_RESP);
    assign w_rd_addr  = (r_rd_state == R_IDLE) ? mem_axi_araddr : r_rd_addr;
    assign w_rd_sel   = decode(w_rd_addr);

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (w_rd_sel)
            SEL_RAM:  w_rd_data = r_mem[w_rd_addr[ADDR_LSB +: IDX_W]];
            SEL_PASS: w_rd_data = {{(DATA_WIDTH-1){1'b0}}, tests_passed};
            SEL_ERR:  w_rd_resp = RESP_SLVERR;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rd_cnt  <= '0;
            r_rd_addr <= '0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            if (w_ar_fire) begin
                r_rd_addr <= mem_axi_araddr;
                r_rd_cnt  <= 4'(RD_WAIT);
            end else if (r_rd_state == R_WAIT) begin
                r_rd_cnt  <= r_rd_cnt - 4'd1;
            end
            if (w_rd_enter) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_resp;
            end else if (r_rvalid && mem_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // ---------------- write channel ----------------
    wr_state_t             r_wr_state, w_wr_next;
    logic [3:0]            r_wr_cnt;
    logic                  r_aw_held, r_w_held, w_awready, w_wready;
    logic                  w_aw_fire, w_w_fire, w_both, w_wr_commit;
    logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data;
    logic [STRB_W-1:0]     r_wr_strb, w_wr_strb;
    logic                  r_bvalid, r_console_valid, r_tests_passed;
    logic [1:0]            r_bresp;
    logic [7:0]            r_console_data;
    sel_t                  w_wr_sel;

    always_ff @(posedge clk) begin
        if (!resetn) r_wr_state <= W_IDLE;
        else         r_wr_state <= w_wr_next;
    end

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if (w_both) w_wr_next = (WR_WAIT == 0) ? W_RESP : W_WAIT;
            W_WAIT:  if (r_wr_cnt <= 4'd1) w_wr_next = W_RESP;
            W_RESP:  if (mem_axi_bready) w_wr_next = W_IDLE;
            default: w_wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        w_awready = r_live && (r_wr_state == W_IDLE) && !r_aw_held;
        w_wready  = r_live && (r_wr_state == W_IDLE) && !r_w_held;
    end

    assign w_aw_fire = mem_axi_awvalid && w_awready;
    assign w_w_fire  = mem_axi_wvalid && w_wready;
    assign w_both    = (r_aw_held || w_aw_fire) && (r_w_held || w_w_fire);
    assign w_wr_addr = r_aw_held ? r_wr_addr : mem_axi_awaddr;
    assign w_wr_data = r_w_held  ? r_wr_data : mem_axi_wdata;
    assign w_wr_strb = r_w_held  ? r_wr_strb : mem_axi_wstrb;
    assign w_wr_sel  = decode(w_wr_addr);
    // Gating with resetn guarantees an abandoned transaction never reaches the RAM.
    assign w_wr_commit = resetn && (w_wr_next == W_RESP) && (r_wr_state != W_RESP);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_cnt        <= '0;
            r_aw_held       <= 1'b0;
            r_w_held        <= 1'b0;
            r_wr_addr       <= '0;
            r_wr_data       <= '0;
            r_wr_strb       <= '0;
            r_bvalid        <= 1'b0;
            r_bresp         <= RESP_OKAY;
            r_console_valid <= 1'b0;
            r_console_data  <= '0;
            r_tests_passed  <= 1'b0;
        end else begin
            r_console_valid <= 1'b0;
            if (w_aw_fire) begin
                r_aw_held <= 1'b1;
                r_wr_addr <= mem_axi_awaddr;
            end
            if (w_w_fire) begin
                r_w_held  <= 1'b1;
                r_wr_data <= mem_axi_wdata;
                r_wr_strb <= mem_axi_wstrb;
            end
            if (r_wr_state == W_IDLE && w_both) r_wr_cnt <= 4'(WR_WAIT);
            else if (r_wr_state == W_WAIT)      r_wr_cnt <= r_wr_cnt - 4'd1;
            if (w_wr_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= (w_wr_sel == SEL_ERR) ? RESP_SLVERR : RESP_OKAY;
                if (w_wr_sel == SEL_CONSOLE && w_wr_strb[0]) begin
                    r_console_valid <= 1'b1;
                    r_console_data  <= w_wr_data[7:0];
                end
                if (w_wr_sel == SEL_PASS && w_wr_data[31:0] == PASS_VALUE)
                    r_tests_passed <= 1'b1;
            end else if (r_bvalid && mem_axi_bready) begin
                r_bvalid  <= 1'b0;
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    // NOTE: the RAM has no reset branch so it maps onto block RAM and keeps its contents across resetn.
    always_ff @(posedge clk) begin
        if (w_wr_commit && w_wr_sel == SEL_RAM) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_wr_strb[b]) r_mem[w_wr_addr[ADDR_LSB +: IDX_W]][b*8 +: 8] <= w_wr_data[b*8 +: 8];
            end
        end
    end

    assign mem_axi_arready = w_arready;
    assign mem_axi_rvalid  = r_rvalid;
    assign mem_axi_rdata   = r_rdata;
    assign mem_axi_rresp   = r_rresp;
    assign mem_axi_awready = w_awready;
    assign mem_axi_wready  = w_wready;
    assign mem_axi_bvalid  = r_bvalid;
    assign mem_axi_bresp   = r_bresp;
    assign console_valid   = r_console_valid;
    assign console_data    = r_console_data;
    assign tests_passed    = r_tests_passed;

endmodule

// File: tb/tb_axil_mem_slave.sv
// Self-checking bench for axil_mem_slave: two instances (zero and two wait states)
// driven by directed and $urandom transactions, checked against a byte-level memory model.

module tb_axil_mem_slave;

    localparam logic [31:0] CON_A  = 32'h1000_0000;
    localparam logic [31:0] PASS_A = 32'h2000_0000;
    localparam logic [31:0] PASS_V = 32'd123456789;
    localparam logic [31:0] MEM_SZ = 32'd131072;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       awvalid = '0, wvalid = '0, bready = '0, arvalid = '0, rready = '0;
    logic [1:0][31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [1:0][3:0]  wstrb = '0;
    logic [2:0]       prot = 3'b000;
    wire  [1:0]       awready, wready, bvalid, arready, rvalid, console_valid, tests_passed;
    wire  [1:0][31:0] rdata;
    wire  [1:0][1:0]  bresp, rresp;
    wire  [1:0][7:0]  console_data;

    axil_mem_slave #(.RD_WAIT(0), .WR_WAIT(0)) u_dut0 (
        .clk(clk), .resetn(resetn),
        .mem_axi_awvalid(awvalid[0]), .mem_axi_awready(awready[0]), .mem_axi_awaddr(awaddr[0]),
        .mem_axi_awprot(prot), .mem_axi_wvalid(wvalid[0]), .mem_axi_wready(wready[0]),
        .mem_axi_wdata(wdata[0]), .mem_axi_wstrb(wstrb[0]), .mem_axi_bvalid(bvalid[0]),
        .mem_axi_bready(bready[0]), .mem_axi_bresp(bresp[0]), .mem_axi_arvalid(arvalid[0]),
        .mem_axi_arready(arready[0]), .mem_axi_araddr(araddr[0]), .mem_axi_arprot(prot),
        .mem_axi_rvalid(rvalid[0]), .mem_axi_rready(rready[0]), .mem_axi_rdata(rdata[0]),
        .mem_axi_rresp(rresp[0]), .console_valid(console_valid[0]), .console_data(console_data[0]),
        .tests_passed(tests_passed[0])
    );

    axil_mem_slave #(.RD_WAIT(2), .WR_WAIT(2)) u_dut1 (
        .clk(clk), .resetn(resetn),
        .mem_axi_awvalid(awvalid[1]), .mem_axi_awready(awready[1]), .mem_axi_awaddr(awaddr[1]),
        .mem_axi_awprot(prot), .mem_axi_wvalid(wvalid[1]), .mem_axi_wready(wready[1]),
        .mem_axi_wdata(wdata[1]), .mem_axi_wstrb(wstrb[1]), .mem_axi_bvalid(bvalid[1]),
        .mem_axi_bready(bready[1]), .mem_axi_bresp(bresp[1]), .mem_axi_arvalid(arvalid[1]),
        .mem_axi_arready(arready[1]), .mem_axi_araddr(araddr[1]), .mem_axi_arprot(prot),
        .mem_axi_rvalid(rvalid[1]), .mem_axi_rready(rready[1]), .mem_axi_rdata(rdata[1]),
        .mem_axi_rresp(rresp[1]), .console_valid(console_valid[1]), .console_data(console_data[1]),
        .tests_passed(tests_passed[1])
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int con_cnt [2] = '{0, 0};
    logic [7:0] con_last [2];
    logic [31:0] mem_mdl [int unsigned];
    bit tp_mdl [2] = '{1'b0, 1'b0};

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (console_valid[d]) begin
                con_cnt[d]++;
                con_last[d] = console_data[d];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int waits(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic int unsigned mkey(input int d, input logic [31:0] a);
        return (int'(d) << 20) | int'(a[16:2]);
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return (a < MEM_SZ || a == CON_A || a == PASS_A) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] mdl_read(input int d, input logic [31:0] a);
        if (a < MEM_SZ)  return mem_mdl.exists(mkey(d, a)) ? mem_mdl[mkey(d, a)] : 32'h0;
        if (a == PASS_A) return {31'd0, tp_mdl[d]};
        return 32'h0;
    endfunction

    task automatic mdl_write(input int d, input logic [31:0] a, input logic [31:0] v, input logic [3:0] s);
        logic [31:0] w;
        if (a < MEM_SZ) begin
            w = mdl_read(d, a);
            for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = v[b*8 +: 8];
            mem_mdl[mkey(d, a)] = w;
        end else if (a == PASS_A && v == PASS_V) begin
            tp_mdl[d] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input int d, input logic [31:0] a, input logic [31:0] v, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_stall, output logic [1:0] resp);
        int t, cap;
        bit aw_done, w_done, a_fire, d_fire;
        t = 0; cap = 0; aw_done = 0; w_done = 0;
        awaddr[d] = a; wdata[d] = v; wstrb[d] = s; bready[d] = 1'b0;
        while (!(aw_done && w_done) && t < 60) begin
            awvalid[d] = !aw_done && (t >= aw_dly);
            wvalid[d]  = !w_done && (t >= w_dly);
            a_fire = awvalid[d] && awready[d];
            d_fire = wvalid[d] && wready[d];
            tick();
            t++;
            if (a_fire) begin aw_done = 1; cap = cyc; end
            if (d_fire) begin w_done = 1; if (cyc > cap) cap = cyc; end
            if (d_fire && !aw_done) check("wready_drop_after_w", wready[d], 1'b0);
        end
        awvalid[d] = 1'b0;
        wvalid[d]  = 1'b0;
        if (!(aw_done && w_done)) begin
            check("write_capture_timeout", 0, 1);
            resp = 2'b11;
            return;
        end
        t = 0;
        while (!bvalid[d] && t < 40) begin tick(); t++; end
        check("bvalid_latency", cyc - cap, waits(d));
        if (b_stall > 0) begin
            repeat (b_stall) tick();
            check("bvalid_held_in_stall", bvalid[d], 1'b1);
            check("awready_low_in_stall", awready[d], 1'b0);
        end
        resp = bresp[d];
        bready[d] = 1'b1;
        tick();
        bready[d] = 1'b0;
        check("bvalid_clear", bvalid[d], 1'b0);
    endtask

    task automatic axi_read(input int d, input logic [31:0] a, input int r_stall,
                            output logic [31:0] v, output logic [1:0] resp);
        int t, cap;
        bit done, fire;
        t = 0; cap = 0; done = 0;
        araddr[d] = a; arvalid[d] = 1'b1; rready[d] = 1'b0;
        while (!done && t < 60) begin
            fire = arready[d];
            tick();
            t++;
            if (fire) begin done = 1; cap = cyc; end
        end
        arvalid[d] = 1'b0;
        if (!done) begin
            check("ar_timeout", 0, 1);
            v = '0; resp = 2'b11;
            return;
        end
        t = 0;
        while (!rvalid[d] && t < 40) begin tick(); t++; end
        check("rvalid_latency", cyc - cap, waits(d));
        if (r_stall > 0) begin
            repeat (r_stall) tick();
            check("rvalid_held_in_stall", rvalid[d], 1'b1);
            check("arready_low_in_stall", arready[d], 1'b0);
        end
        v = rdata[d];
        resp = rresp[d];
        rready[d] = 1'b1;
        tick();
        rready[d] = 1'b0;
        check("rvalid_clear", rvalid[d], 1'b0);
    endtask

    task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] v, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_stall);
        logic [1:0] r;
        axi_write(d, a, v, s, aw_dly, w_dly, b_stall, r);
        check("bresp", r, exp_resp(a));
        mdl_write(d, a, v, s);
    endtask

    task automatic do_read(input int d, input logic [31:0] a, input int r_stall);
        logic [31:0] v;
        logic [1:0] r;
        axi_read(d, a, r_stall, v, r);
        check("rresp", r, exp_resp(a));
        check("rdata", v, mdl_read(d, a));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v, old, pool [6], a;
        logic [1:0] r1, r2;
        int c0;

        // Reset state
        repeat (3) tick();
        check("rst_arready", arready, 2'b00);
        check("rst_awready", awready, 2'b00);
        check("rst_wready", wready, 2'b00);
        check("rst_bvalid", bvalid, 2'b00);
        check("rst_rvalid", rvalid, 2'b00);
        check("rst_resp", {bresp, rresp}, 8'h00);
        check("rst_rdata", rdata, 64'h0);
        check("rst_console", {console_valid, console_data}, 18'h0);
        check("rst_tests_passed", tests_passed, 2'b00);
        resetn = 1'b1;
        check("arready_before_first_edge", arready, 2'b00);
        tick();
        check("arready_after_release", arready, 2'b11);
        check("awready_wready_after_release", {awready, wready}, 4'hF);

        // Basic write/read and byte strobes
        do_write(0, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_read(0, 32'h100, 0);
        do_write(0, 32'h40, 32'h0, 4'hF, 0, 0, 0);
        do_write(0, 32'h40, 32'h11223344, 4'b0101, 0, 0, 0);
        axi_read(0, 32'h40, 0, v, r1);
        check("strobe_merge", v, 32'h00220044);

        // Error responses
        axi_read(0, 32'h0002_0000, 1, v, r1);
        check("err_rresp", r1, 2'b10);
        check("err_rdata", v, 32'h0);
        do_write(0, 32'h0, 32'hCAFEF00D, 4'hF, 0, 0, 0);
        do_write(0, 32'h3000_0000, 32'h5555AAAA, 4'hF, 1, 0, 0);
        do_read(0, 32'h0, 0);

        // MMIO
        c0 = con_cnt[0];
        do_write(0, CON_A, 32'h0000_0041, 4'h1, 0, 0, 0);
        tick();
        check("console_pulse_count", con_cnt[0] - c0, 1);
        check("console_data", con_last[0], 8'h41);
        do_read(0, CON_A, 0);
        do_write(0, PASS_A, PASS_V, 4'hF, 0, 0, 0);
        check("tests_passed_set", tests_passed[0], 1'b1);
        do_write(0, PASS_A, 32'h0, 4'hF, 0, 0, 0);
        check("tests_passed_sticky", tests_passed[0], 1'b1);
        axi_read(0, PASS_A, 0, v, r1);
        check("pass_readback", v, 32'h1);

        // W ahead of AW with wait states and bready stall
        do_write(1, 32'h200, 32'h0BADC0DE, 4'hF, 3, 0, 4);
        do_read(1, 32'h200, 2);

        // Overlapping same-address read and write with equal waits
        for (int d = 0; d < 2; d++) begin
            do_write(d, 32'h300, 32'h01010101 * (d + 1), 4'hF, 0, 0, 0);
            old = mdl_read(d, 32'h300);
            fork
                axi_write(d, 32'h300, 32'hFEEDFACE, 4'hF, 0, 0, 0, r1);
                axi_read(d, 32'h300, 0, v, r2);
            join
            check("overlap_returns_old", v, old);
            mdl_write(d, 32'h300, 32'hFEEDFACE, 4'hF);
            do_read(d, 32'h300, 0);
        end

        // Randomised traffic
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 6; i++) begin
                pool[i] = 32'($urandom_range(0, 32767)) << 2;
                do_write(d, pool[i], $urandom, 4'hF, 0, 0, 0);
            end
            for (int i = 0; i < 30; i++) begin
                a = pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) a = {4'h4, 28'($urandom)};
                if ($urandom_range(0, 1) == 1)
                    do_write(d, a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                             $urandom_range(0, 3));
                else
                    do_read(d, a, $urandom_range(0, 3));
            end
        end

        // Reset during R_WAIT/W_WAIT abandons both transactions
        do_write(1, PASS_A, PASS_V, 4'hF, 0, 0, 0);
        do_write(1, 32'h500, 32'h12345678, 4'hF, 0, 0, 0);
        do_write(1, 32'h504, 32'h9ABCDEF0, 4'hF, 0, 0, 0);
        araddr[1] = 32'h500; arvalid[1] = 1'b1;
        awaddr[1] = 32'h504; wdata[1] = 32'hFFFF0000; wstrb[1] = 4'hF;
        awvalid[1] = 1'b1; wvalid[1] = 1'b1;
        tick();
        arvalid[1] = 1'b0; awvalid[1] = 1'b0; wvalid[1] = 1'b0;
        check("busy_arready_low", arready[1], 1'b0);
        tick();
        resetn = 1'b0;
        tick();
        check("reset_rvalid", rvalid[1], 1'b0);
        check("reset_bvalid", bvalid[1], 1'b0);
        check("reset_tests_passed", tests_passed, 2'b00);
        tp_mdl[0] = 1'b0;
        tp_mdl[1] = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        check("post_reset_rvalid", rvalid[1], 1'b0);
        check("post_reset_arready", arready[1], 1'b1);
        do_read(1, 32'h500, 0);
        do_read(1, 32'h504, 0);
        do_read(0, 32'h100, 0);
        do_read(1, PASS_A, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axil_mem_slave.md
# axil_mem_slave

Synthesizable, parametrised AXI4-Lite memory slave for the picorv32_axi test SoC, replacing the behavioural bench memory in FPGA and simulation builds. It has independent read and write state machines, programmable wait states and error responses for out-of-range addresses. It includes a memory-mapped console byte port and a sticky test-pass flag. It sits directly on the core's `mem_axi_*` bus.

## Interface
- `ADDR_WIDTH`, 32: AXI address width.
- `DATA_WIDTH`, 32: data width; 32 or 64.
- `MEM_BYTES`, 131072: RAM size in bytes; power of two, a multiple of DATA_WIDTH/8.
- `RD_WAIT`, 0: extra cycles between AR handshake and rvalid; range 0..15.
- `WR_WAIT`, 0: extra cycles between write-address/data capture and bvalid; range 0..15.
- `CONSOLE_ADDR`, 32'h1000_0000: console byte register address.
- `PASS_ADDR`, 32'h2000_0000: test-pass register address.
- `PASS_VALUE`, 123456789: value that sets tests_passed.

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  synchronous, active-low reset
- `mem_axi_awvalid` / `mem_axi_awready`  in/out  1  write address handshake
- `mem_axi_awaddr`  in  ADDR_WIDTH  write address
- `mem_axi_awprot`  in  3  ignored
- `mem_axi_wvalid` / `mem_axi_wready`  in/out  1  write data handshake
- `mem_axi_wdata`  in  DATA_WIDTH  write data
- `mem_axi_wstrb`  in  DATA_WIDTH/8  byte enables
- `mem_axi_bvalid` / `mem_axi_bready`  out/in  1  write response handshake
- `mem_axi_bresp`  out  2  00 OKAY, 10 SLVERR
- `mem_axi_arvalid` / `mem_axi_arready`  in/out  1  read address handshake
- `mem_axi_araddr`  in  ADDR_WIDTH  read address
- `mem_axi_arprot`  in  3  ignored
- `mem_axi_rvalid` / `mem_axi_rready`  out/in  1  read data handshake
- `mem_axi_rdata`  out  DATA_WIDTH  read data
- `mem_axi_rresp`  out  2  read response
- `console_valid`  out  1  one-cycle pulse per console byte
- `console_data`  out  8  console byte
- `tests_passed`  out  1  sticky pass flag

## Operation
- Word index = addr[log2(MEM_BYTES)-1 : log2(DATA_WIDTH/8)]. Low byte-offset bits are ignored.
- An address is in range when addr < MEM_BYTES. An address equal to CONSOLE_ADDR or PASS_ADDR is an MMIO hit. Any other address is an error.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, capture the address, load the wait counter with RD_WAIT, and go to R_WAIT, or to R_RESP when RD_WAIT=0.
  - R_WAIT: decrement the counter; at 0 go to R_RESP.
  - R_RESP: on entry, register rdata and rresp and assert rvalid. Hold rdata, rresp and rvalid stable until rready; then return to R_IDLE.
- Read data:
  - RAM: the word at the captured index, OKAY.
  - PASS_ADDR: {0, tests_passed}, OKAY.
  - CONSOLE_ADDR: 0, OKAY.
  - Error: 0, SLVERR.
- Write FSM:
  - W_IDLE: awready=1 until AW is captured; wready=1 until W is captured. AW and W may arrive in either order or together. When both are held, load the counter with WR_WAIT and go to W_WAIT, or to W_RESP when WR_WAIT=0.
  - W_WAIT: count down to 0, then go to W_RESP.
  - W_RESP: on entry, commit the write and assert bvalid with bresp. Hold until bready; then return to W_IDLE with awready=wready=1.
- Write commit:
  - RAM: per-byte update gated by wstrb.
  - CONSOLE_ADDR: if wstrb[0], pulse console_valid for one cycle with wdata[7:0].
  - PASS_ADDR: if wdata[31:0]==PASS_VALUE, set tests_passed; it stays set until reset.
  - Error: no state change, bresp=SLVERR.
- The read and write paths are fully independent and may be busy at the same time.

## Timing
- Reset values: all ready, valid and resp outputs 0; rdata 0; console_valid 0; console_data 0; tests_passed 0.
- The RAM array is not reset; its contents survive resetn.
- arready, awready and wready rise on the first cycle after resetn deasserts.
- Reset mid-transaction abandons the transaction: no write is committed and no response is issued.
- Read latency: AR handshake in cycle N gives rvalid in cycle N+1+RD_WAIT. Back-to-back throughput is one read per 2+RD_WAIT cycles when rready is held high.
- Write latency: with the later of AW/W captured in cycle N, bvalid and the commit occur in cycle N+1+WR_WAIT.
- Same-address read and write:
  - If the read's R_RESP entry and the write commit occur in the same cycle, the read returns the old data.
  - If the commit is in an earlier cycle, the read returns the new data.
- Stalled rready or bready holds the FSM in R_RESP or W_RESP indefinitely. arready, or awready/wready respectively, stays 0 during that time.

## Test plan
- Reset release, RD_WAIT=0: write 32'hDEADBEEF to 0x100 with wstrb=4'hF, then read 0x100. Required: bvalid 1 cycle after capture, bresp=00; rvalid at N+1; rdata=DEADBEEF, rresp=00.
- Byte strobes: write 32'h11223344 to 0x40 with wstrb=4'b0101 over a prior value of 0. Required: a read returns 32'h00220044.
- Ordering and stalls: present W 3 cycles before AW, with WR_WAIT=2 and bready low for 4 cycles. Required: wready drops after W capture; bvalid 3 cycles after AW capture; bvalid held stable until bready.
- Error responses: read from 0x0002_0000 with MEM_BYTES=131072. Required: rresp=10, rdata=0. Write to 0x3000_0000. Required: bresp=10 and no RAM change.
- MMIO: write 8'h41 to CONSOLE_ADDR. Required: console_valid for exactly 1 cycle, console_data=8'h41. Write 123456789 to PASS_ADDR. Required: tests_passed=1, and it stays 1 after a later write of 0. A read of PASS_ADDR returns 1.
- Concurrency and reset: run an overlapping read and write to the same address with equal waits. Required: the read returns the old value. Assert resetn low during R_WAIT. Required: rvalid stays 0, tests_passed clears, RAM contents are unchanged.
